ascii_field_reader: RTL and testbench



---
 rtl/ascii_field_reader_if.sv | 26 ++
 rtl/ascii_field_reader.sv | 133 +++++++++++++
 tb/tb_ascii_field_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_field_reader_if.sv
// Request/result handshake plus character-buffer read port for ascii_field_reader.
// slave = the reader itself, master = the requester / buffer side.
interface ascii_field_reader_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic [5:0]        row;
  logic [6:0]        col;
  logic              busy;
  logic              done;
  logic [31:0]       value;
  logic [1:0]        err_code;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  modport slave (
    input  start, row, col, rd_data,
    output busy, done, value, err_code, rd_en, rd_addr
  );

  modport master (
    output start, row, col, rd_data,
    input  busy, done, value, err_code, rd_en, rd_addr
  );
endinterface

// File: rtl/ascii_field_reader.sv
// Parses one sign+ten-digit decimal text field from the character buffer
// into a 32-bit two's-complement value, one character read per two cycles.
module ascii_field_reader #(
  parameter int COLS      = 80,
  parameter int FIELD_LEN = 11,
  parameter int ADDR_W    = 13
) (
  input logic               clk,
  input logic               rst,
  ascii_field_reader_if.slave bus
);

  localparam int POS_W = $clog2(FIELD_LEN);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_SIGN  = 2'd1;
  localparam logic [1:0] E_DIGIT = 2'd2;
  localparam logic [1:0] E_OVF   = 2'd3;

  logic [1:0]        state;
  logic [POS_W-1:0]  pos;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] start_base;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [33:0]       mag;
  logic [33:0]       mag_next;
  logic              neg;
  logic [31:0]       value_q;
  logic [1:0]        err_q;

  logic [7:0]        ch;
  logic              is_digit;
  logic              last_pos;
  logic              ovf;
  logic [1:0]        cap_err;
  logic              cap_stop;
  logic              unused_colour;

  assign ch            = bus.rd_data[31:24];
  assign unused_colour = ^bus.rd_data[23:0];
  assign is_digit      = (ch >= 8'h30) && (ch <= 8'h39);
  assign last_pos      = (pos == POS_W'(FIELD_LEN - 1));
  assign start_base    = ADDR_W'(32'(COLS) * 32'(bus.row) + 32'(bus.col));

  // mag*10 as (mag<<3)+(mag<<1); a valid digit's low nibble is its value
  assign mag_next = {mag[30:0], 3'b000} + {mag[32:0], 1'b0} + {30'd0, ch[3:0]};
  assign ovf      = neg ? (mag_next > 34'd2147483648) : (mag_next > 34'd2147483647);

  always_comb begin
    cap_err  = E_OK;
    cap_stop = 1'b0;
    if (pos == '0) begin
      if (ch != 8'h2B && ch != 8'h2D) begin
        cap_err  = E_SIGN;
        cap_stop = 1'b1;
      end
    end else if (!is_digit) begin
      cap_err  = E_DIGIT;
      cap_stop = 1'b1;
    end else if (last_pos) begin
      cap_err  = ovf ? E_OVF : E_OK;
      cap_stop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= '0;
      base      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      value_q   <= '0;
      err_q     <= E_OK;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_ISSUE;
            base      <= start_base;
            pos       <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            value_q   <= '0;
            err_q     <= E_OK;
            rd_en_q   <= 1'b1;
            rd_addr_q <= start_base;
          end
        end
        S_ISSUE: begin
          rd_en_q <= 1'b0;
          state   <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (pos == '0) begin
            neg <= (ch == 8'h2D);
          end else if (is_digit) begin
            mag <= mag_next;
          end
          if (cap_stop) begin
            state <= S_DONE;
            err_q <= cap_err;
            if (cap_err == E_OK) begin
              value_q <= neg ? (~mag_next[31:0] + 32'd1) : mag_next[31:0];
            end
          end else begin
            state     <= S_ISSUE;
            pos       <= pos + POS_W'(1);
            rd_en_q   <= 1'b1;
            rd_addr_q <= base + ADDR_W'(pos) + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_ISSUE) || (state == S_CAPTURE);
  assign bus.done     = (state == S_DONE);
  assign bus.value    = value_q;
  assign bus.err_code = err_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_ascii_field_reader.sv
// Directed bench for ascii_field_reader: character-buffer model, per-cycle
// reference of the request timeline, and literal expectations per field.
module tb_ascii_field_reader;

  localparam int ADDR_W = 13;
  localparam int MEMSZ  = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascii_field_reader_if #(.ADDR_W(ADDR_W)) bus ();

  ascii_field_reader #(
    .COLS(80), .FIELD_LEN(11), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  byte unsigned mem [MEMSZ];
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // character buffer: one-cycle read latency, random colour, garbage when idle
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= {mem[bus.rd_addr], 24'($urandom)};
    else           bus.rd_data <= $urandom;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int base_of(input int r, input int c);
    return (80 * r + c) % MEMSZ;
  endfunction

  // Reference parse: sign, ten decimal digits, range check against int32.
  function automatic void parse(input int b, output logic [31:0] v,
                                output logic [1:0] e, output int last);
    longint m;
    bit ng;
    int ch;
    v = '0; e = 2'd0; last = 0; m = 0; ng = 0;
    ch = int'(mem[b % MEMSZ]);
    if (ch == 43) ng = 0;
    else if (ch == 45) ng = 1;
    else begin e = 2'd1; return; end
    for (int i = 1; i < 11; i++) begin
      ch = int'(mem[(b + i) % MEMSZ]);
      if (ch < 48 || ch > 57) begin e = 2'd2; last = i; return; end
      m = m * 10 + longint'(ch - 48);
    end
    last = 10;
    if (m > (ng ? 64'sd2147483648 : 64'sd2147483647)) e = 2'd3;
    else v = ng ? 32'(-m) : 32'(m);
  endfunction

  // Request timeline model: o = cycles since acceptance (1 = first read cycle)
  bit          m_live = 0;
  bit          m_on   = 0;
  int          o, m_doff, m_base, p_last;
  logic [31:0] m_val, p_val;
  logic [1:0]  m_err, p_err;
  logic [12:0] m_addr;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_live = 1; m_on = 0; m_val = '0; m_err = '0; m_addr = '0;
    end else if (m_on) begin
      o++;
      if (o > m_doff) m_on = 0;
      else begin
        if ((o % 2) == 1 && o <= m_doff - 2) m_addr = 13'((m_base + (o - 1) / 2) % MEMSZ);
        if (o == m_doff) begin m_val = p_val; m_err = p_err; end
      end
    end else if (bus.start) begin
      m_on = 1; o = 1;
      m_base = base_of(int'(bus.row), int'(bus.col));
      parse(m_base, p_val, p_err, p_last);
      m_doff = 3 + 2 * p_last;
      m_val = '0; m_err = '0; m_addr = 13'(m_base);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("busy",     64'(bus.busy),     64'(m_on && o <= m_doff - 1));
      chk("done",     64'(bus.done),     64'(m_on && o == m_doff));
      chk("rd_en",    64'(bus.rd_en),    64'(m_on && (o % 2) == 1 && o <= m_doff - 2));
      chk("rd_addr",  64'(bus.rd_addr),  64'(m_addr));
      chk("value",    64'(bus.value),    64'(m_val));
      chk("err_code", 64'(bus.err_code), 64'(m_err));
    end
  end

  task automatic put_field(input int r, input int c, input string s);
    int b = base_of(r, c);
    for (int i = 0; i < 11; i++) mem[(b + i) % MEMSZ] = s[i];
  endtask

  task automatic wait_done(input int k, output int off, output int pulses,
                           output int first, output logic [31:0] dv, output logic [1:0] de);
    off = -1; pulses = 0; first = -1; dv = 'x; de = 'x;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.rd_en) begin
        pulses++;
        if (first < 0) first = int'(bus.rd_addr);
      end
      if (bus.done) begin
        off = cyc + 1 - k; dv = bus.value; de = bus.err_code;
        break;
      end
    end
    if (off < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within 60 cycles of start edge %0d", k);
    end
  endtask

  task automatic run_field(input int r, input int c, input string s, input logic [31:0] ev,
                           input logic [1:0] ee, input int eoff, input int epulses);
    int k, off, pulses, first, pl;
    logic [31:0] dv, pv;
    logic [1:0]  de, pe;
    put_field(r, c, s);
    parse(base_of(r, c), pv, pe, pl);
    chk({"model_value ", s}, 64'(pv), 64'(ev));
    chk({"model_err ", s}, 64'(pe), 64'(ee));
    bus.row = 6'(r); bus.col = 7'(c); bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc; bus.start = 1'b0;
    wait_done(k, off, pulses, first, dv, de);
    chk({"done_latency ", s}, 64'(off), 64'(eoff));
    chk({"rd_pulses ", s}, 64'(pulses), 64'(epulses));
    chk({"first_addr ", s}, 64'(first), 64'(base_of(r, c)));
    chk({"value ", s}, 64'(dv), 64'(ev));
    chk({"err_code ", s}, 64'(de), 64'(ee));
    @(posedge clk); #1;
  endtask

  initial begin
    int k, off, pulses, first;
    logic [31:0] dv;
    logic [1:0]  de;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'h20;
    rst = 1'b1; bus.start = 1'b0; bus.row = '0; bus.col = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  64'(bus.busy),    64'd0);
    chk("reset_addr",  64'(bus.rd_addr), 64'd0);
    chk("reset_value", 64'(bus.value),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_field(5,  0,  "+0000000042", 32'd42,         2'd0, 23, 11);
    run_field(32, 0,  "-2147483648", 32'h8000_0000,  2'd0, 23, 11);
    run_field(33, 3,  "-0000000001", 32'hFFFF_FFFF,  2'd0, 23, 11);
    run_field(34, 0,  "+2147483648", 32'd0,          2'd3, 23, 11);
    run_field(35, 0,  "+9999999999", 32'd0,          2'd3, 23, 11);
    run_field(36, 0,  "X0000000001", 32'd0,          2'd1, 3,  1);
    run_field(37, 0,  "+000 000001", 32'd0,          2'd2, 11, 5);
    run_field(38, 0,  "-0000000000", 32'd0,          2'd0, 23, 11);
    run_field(39, 69, "+2147483647", 32'h7FFF_FFFF,  2'd0, 23, 11);
    run_field(63, 127,"-2147483649", 32'd0,          2'd3, 23, 11);
    run_field(10, 20, "-0012345678", 32'hFF43_9EB2,  2'd0, 23, 11);

    // handshake: starts at k+5 and k+23 ignored, k+24 accepted
    put_field(40, 0, "+0000000123");
    bus.row = 6'd40; bus.col = 7'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc; bus.start = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      bus.start = (e == 5 || e == 23 || e == 24);
      @(posedge clk); #1;
      if (e == 22) begin
        chk("hs_done_k23",  64'(bus.done),  64'd1);
        chk("hs_value_k23", 64'(bus.value), 64'd123);
      end
      if (e == 23) chk("hs_idle_k24", 64'({bus.busy, bus.done}), 64'd0);
      if (e == 24) chk("hs_busy_k25", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    wait_done(k + 24, off, pulses, first, dv, de);
    chk("hs_second_latency", 64'(off), 64'd23);
    chk("hs_second_value",   64'(dv),  64'd123);
    @(posedge clk); #1;

    // reset mid-parse at k+10
    put_field(45, 0, "+0000000099");
    bus.row = 6'd45; bus.col = 7'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    k = cyc; bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy",  64'(bus.busy),     64'd0);
    chk("rst_done",  64'(bus.done),     64'd0);
    chk("rst_rd_en", 64'(bus.rd_en),    64'd0);
    chk("rst_addr",  64'(bus.rd_addr),  64'd0);
    chk("rst_value", 64'(bus.value),    64'd0);
    chk("rst_err",   64'(bus.err_code), 64'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    run_field(46, 0, "+0000000007", 32'd7, 2'd0, 23, 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
